// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner with row synchronizer and press/release debounce.
// Drives one active-low column at a time, latches the first pressed key found, and emits one
// key_valid pulse per debounced press while shifting the last two keys into digit_new/old.
module keypad_scan #(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDbPress, StHeld, StDbRelease} state_e;

  state_e          state_q, state_d;
  logic [3:0]      rows_meta_q, rows_s_q;
  logic [SetW-1:0] settle_q, settle_d;
  logic [DbW-1:0]  db_q, db_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic [3:0]      digit_new_q, digit_new_d;
  logic [3:0]      digit_old_q, digit_old_d;

  logic            any_low;
  logic [1:0]      low_idx;
  logic            row_low;
  logic            settle_done;
  logic            db_done;
  logic [3:0]      key_map;

  // Hex legend of the keypad at (row, col).
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous rows; idles high like the pull-ups.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta_q <= 4'hF;
      rows_s_q    <= 4'hF;
    end else begin
      rows_meta_q <= rows;
      rows_s_q    <= rows_meta_q;
    end
  end

  // Decode conditions on the synchronized rows and counters.
  always_comb begin
    any_low     = ~&rows_s_q;
    low_idx     = 2'd0;
    if (!rows_s_q[0])      low_idx = 2'd0;
    else if (!rows_s_q[1]) low_idx = 2'd1;
    else if (!rows_s_q[2]) low_idx = 2'd2;
    else if (!rows_s_q[3]) low_idx = 2'd3;
    row_low     = ~rows_s_q[row_q];
    settle_done = (settle_q == SetLast);
    db_done     = (db_q == DbLast);
    key_map     = map_key(row_q, col_q);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StScan;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StScan:      if (settle_done && any_low) state_d = StDbPress;
      StDbPress:   if (!row_low) state_d = StScan;
                   else if (db_done) state_d = StHeld;
      StHeld:      if (!row_low) state_d = StDbRelease;
      StDbRelease: if (row_low) state_d = StHeld;
                   else if (db_done) state_d = StScan;
      default:     state_d = StScan;
    endcase
  end

  // Datapath next-state: counters clear on every state entry, so they never wrap.
  always_comb begin
    settle_d    = '0;
    db_d        = '0;
    col_d       = col_q;
    row_d       = row_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    unique case (state_q)
      StScan: begin
        if (!settle_done) begin
          settle_d = settle_q + 1'b1;
        end else if (any_low) begin
          row_d = low_idx;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      StDbPress: begin
        if (!row_low) begin
          col_d = col_q + 2'd1;
        end else if (db_done) begin
          key_valid_d = 1'b1;
          key_code_d  = key_map;
          digit_new_d = key_map;
          digit_old_d = digit_new_q;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      StHeld: begin
        db_d = '0;
      end
      StDbRelease: begin
        if (row_low) begin
          db_d = '0;
        end else if (db_done) begin
          col_d = col_q + 2'd1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: begin
        col_d = 2'd0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q    <= '0;
      db_q        <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
    end else begin
      settle_q    <= settle_d;
      db_q        <= db_d;
      col_q       <= col_d;
      row_q       <= row_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
    end
  end

  // Outputs: one active-low column, frozen outside SCAN because col_q only moves there.
  always_comb begin
    cols          = 4'hF;
    cols[col_q]   = 1'b0;
    key_valid     = key_valid_q;
    key_code      = key_code_q;
    digit_new     = digit_new_q;
    digit_old     = digit_old_q;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8.
// A key matrix model pulls a row low whenever a pressed key sits in the driven column.
// Timing notes: Nc is the first negedge a column is driven. With the key already down,
// DB_PRESS is entered at the 4th posedge after that, so key_valid is seen at Nc+12.
// A release at negedge Nh reaches DB_RELEASE at Nh+3 and the next column appears at Nh+11.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [3:0]  digit_new;
  logic [3:0]  digit_old;

  logic [15:0] keys;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_pulse  = 0;

  keypad_scan #(
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_CYCLES(8)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .digit_new(digit_new),
    .digit_old(digit_old)
  );

  always #5 clk = ~clk;

  // Key matrix: keys[r*4+c] pressed shorts row r to column c.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  // Count key_valid pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (key_valid === 1'b1) n_pulse <= n_pulse + 1;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    keys[r*4+c] = v;
  endtask

  task automatic wait_cols(input logic [3:0] exp, input string tag);
    int n;
    n = 0;
    while (cols !== exp && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (cols !== exp) check(tag, cols, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cols"}, cols, 4'hE);
    check({tag, "_valid"}, {3'b000, key_valid}, 4'd0);
    check({tag, "_code"}, key_code, 4'h0);
    check({tag, "_new"}, digit_new, 4'h0);
    check({tag, "_old"}, digit_old, 4'h0);
  endtask

  // Press a key, wait for its column, and check the single event at Nc+12.
  task automatic press_and_check(input int r, input int c, input logic [3:0] mask,
                                 input logic [3:0] code, input logic [3:0] old,
                                 input string tag);
    set_key(r, c, 1'b1);
    wait_cols(mask, {tag, "_reach"});
    tick(8);
    check({tag, "_frozen"}, cols, mask);
    tick(3);
    check({tag, "_early"}, {3'b000, key_valid}, 4'd0);
    tick(1);
    check({tag, "_valid"}, {3'b000, key_valid}, 4'd1);
    check({tag, "_code"}, key_code, code);
    check({tag, "_new"}, digit_new, code);
    check({tag, "_old"}, digit_old, old);
    tick(1);
    check({tag, "_pulse1"}, {3'b000, key_valid}, 4'd0);
    check({tag, "_hold"}, key_code, code);
  endtask

  // Clean release: column stays for 10 negedges, next column at the 11th.
  task automatic release_and_check(input int r, input int c, input logic [3:0] mask,
                                   input logic [3:0] next, input string tag);
    set_key(r, c, 1'b0);
    tick(10);
    check({tag, "_stay"}, cols, mask);
    tick(1);
    check({tag, "_next"}, cols, next);
  endtask

  initial begin
    int unsigned p0;
    logic [3:0]  exp_cols;
    logic [3:0]  one;

    reset = 1'b1;
    keys  = '0;
    one   = 4'b0001;
    tick(2);
    check_reset_vals("rst");

    // 1. Idle scan: each column held 4 cycles, one full rotation and back to col0.
    reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      exp_cols = ~(one << ((i / 4) % 4));
      check("idle_cols", cols, exp_cols);
      if (i % 4 == 3) begin
        check("idle_valid", {3'b000, key_valid}, 4'd0);
        check("idle_code", key_code, 4'h0);
        check("idle_new", digit_new, 4'h0);
      end
      if (i < 16) tick(1);
    end

    // 2. Single clean press of "5" (row1, col1).
    press_and_check(1, 1, 4'b1101, 4'h5, 4'h0, "key5");

    // 3. Release, then "9" (row2, col2).
    release_and_check(1, 1, 4'b1101, 4'b1011, "rel5");
    press_and_check(2, 2, 4'b1011, 4'h9, 4'h5, "key9");
    release_and_check(2, 2, 4'b1011, 4'b0111, "rel9");

    // 4. Bounce: row1 low only 3 cycles inside DB_PRESS, then scanning moves to col2.
    p0 = n_pulse;
    set_key(1, 1, 1'b1);
    wait_cols(4'b1101, "bounce_reach");
    tick(5);
    set_key(1, 1, 1'b0);
    tick(2);
    check("bounce_stay", cols, 4'b1101);
    tick(1);
    check("bounce_next", cols, 4'b1011);
    tick(8);
    check("bounce_nopulse", 4'(n_pulse - p0), 4'd0);
    check("bounce_new", digit_new, 4'h9);

    // 5. Long hold of "A" with a 2-cycle glitch in DB_RELEASE.
    p0 = n_pulse;
    press_and_check(0, 3, 4'b0111, 4'hA, 4'h9, "keyA");
    tick(87);
    set_key(0, 3, 1'b0);
    tick(5);
    set_key(0, 3, 1'b1);
    tick(2);
    set_key(0, 3, 1'b0);
    tick(4);
    check("glitch_stay_a", cols, 4'b0111);
    tick(6);
    check("glitch_stay_b", cols, 4'b0111);
    tick(1);
    check("glitch_next", cols, 4'b1110);
    check("keyA_onepulse", 4'(n_pulse - p0), 4'd1);

    // 6a. Rows 0 and 2 low in col0: lowest row wins, key "1".
    set_key(2, 0, 1'b1);
    press_and_check(0, 0, 4'b1110, 4'h1, 4'hA, "multi");

    // 6b. New press of "5", reset at debounce count 5.
    set_key(0, 0, 1'b0);
    set_key(2, 0, 1'b0);
    set_key(1, 1, 1'b1);
    tick(10);
    check("multi_rel_stay", cols, 4'b1110);
    tick(1);
    check("multi_rel_next", cols, 4'b1101);
    tick(9);
    check("mid_valid", {3'b000, key_valid}, 4'd0);
    check("mid_cols", cols, 4'b1101);
    p0 = n_pulse;
    reset = 1'b1;
    set_key(1, 1, 1'b0);
    #1;
    check_reset_vals("midrst");
    tick(2);
    reset = 1'b0;
    tick(16);
    check("post_rst_nopulse", 4'(n_pulse - p0), 4'd0);
    check("post_rst_cols", cols, 4'b1110);
    check("post_rst_code", key_code, 4'h0);
    check("post_rst_old", digit_old, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 hex matrix keypad, synchronizes and debounces the row inputs, and outputs one key event per physical press. It sits directly upstream of the multiplexed seven-segment display stage. Its two held digits, `digit_new` and `digit_old`, replace the two DIP-switch nibbles as the display mux inputs: the most recent key shows on one display and the previous key on the other. It runs on the same HSOSC-derived clock as the display stage (24 MHz).

## Interface
- `SETTLE_CYCLES`, default 16: clock cycles each column is driven before rows are sampled. Must be ≥ 3 to cover the synchronizer.
- `DEBOUNCE_CYCLES`, default 480000: consecutive stable cycles required to accept a press or a release. 480000 cycles is 20 ms at 24 MHz.
- `clk`, input, 1 bit: system clock.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `rows`, input, 4 bits: keypad rows. Active-low with external pull-ups. Asynchronous to `clk`.
- `cols`, output, 4 bits: keypad column drive. Active-low one-hot; exactly one bit is low at all times.
- `key_code`, output, 4 bits: hex value of the last accepted key.
- `key_valid`, output, 1 bit: single-cycle pulse when a press is accepted.
- `digit_new`, output, 4 bits: most recent accepted key.
- `digit_old`, output, 4 bits: key accepted before `digit_new`.

## Operation
- **Input synchronization:** `rows` passes through a 2-flop synchronizer. All logic uses only the synchronized value, `rows_s`.
- **Key map** (row r, col c → code):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- **FSM states:** SCAN, DB_PRESS, HELD, DB_RELEASE.
- **SCAN:**
  - The settle counter counts 0 to SETTLE_CYCLES-1 for the current column.
  - At count SETTLE_CYCLES-1, sample `rows_s`.
  - If all rows are high: advance the column index (0→1→2→3→0) and clear the settle counter.
  - If any row is low: latch the lowest-index low row and the current column, then go to DB_PRESS. `cols` stays frozen on that column.
- **DB_PRESS:**
  - Clear the debounce counter on entry.
  - Each cycle the latched row bit is low, increment the counter.
  - If the latched row bit is high for any cycle: return to SCAN and advance the column. No event is emitted.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the row still low:
    - pulse `key_valid` on the next cycle;
    - load `key_code` with the mapped code;
    - shift `digit_old <= digit_new` and `digit_new <= code` in that same cycle;
    - go to HELD.
- **HELD:** stay until the latched row bit goes high, then go to DB_RELEASE. Presses in other rows or columns are ignored.
- **DB_RELEASE:**
  - Clear the counter on entry.
  - If the latched row bit goes low: return to HELD. No new event is emitted.
  - On reaching DEBOUNCE_CYCLES-1 cycles with the row high: go to SCAN and advance the column.
- **Simultaneous keys:**
  - Within the sampled column, the lowest row index wins.
  - Keys in other columns are not seen until the held key is released.
- **Counter width:** `$clog2(DEBOUNCE_CYCLES)` bits. The counter saturates and never wraps.

## Timing
- **Reset values:**
  - state SCAN, column index 0, `cols` = 4'b1110;
  - `key_code`, `digit_new`, `digit_old` = 0;
  - `key_valid` = 0;
  - settle counter, debounce counter and synchronizer flops = 0 or idle-high as appropriate (synchronizer = 4'b1111).
- **Reset mid-operation:** takes effect immediately, whatever the state. No `key_valid` pulse is produced for the interrupted press.
- **Idle scan period:** each column is held exactly SETTLE_CYCLES cycles, so a full rotation takes 4×SETTLE_CYCLES cycles.
- **Input latency:** `rows` to `rows_s` is 2 cycles.
- **Press latency:** `key_valid` rises exactly DEBOUNCE_CYCLES cycles after entry to DB_PRESS. It is high for exactly 1 cycle.
- **Output updates:** `key_code` and the digits change in the same cycle `key_valid` is high, and hold until the next accepted press.
- **Event spacing:** at most one `key_valid` per press–release cycle. The minimum spacing between events is 2×DEBOUNCE_CYCLES plus scan time.
- **Release timing:** after DB_RELEASE completes, the next column is driven on the following cycle.

## Test plan
Unless noted, use SETTLE_CYCLES=4 and DEBOUNCE_CYCLES=8.

1. **Reset and idle:** assert `reset`, release, keep `rows`=1111.
   - `cols` = 1110, 1101, 1011, 0111, then 1110, each held 4 cycles.
   - All other outputs stay 0.
2. **Single clean press:** hold key "5" (row1 low while `cols`=1101).
   - `cols` freezes at 1101.
   - One `key_valid` pulse with `key_code`=5, `digit_new`=5, `digit_old`=0.
3. **Second press:** release, then press "9" (row2, col2).
   - `key_valid` pulse with `digit_new`=9, `digit_old`=5.
4. **Bounce rejection:** row1 low for 3 cycles during DB_PRESS, then high.
   - No `key_valid`.
   - Scanning resumes at the next column (`cols`=1011).
5. **Long hold with release bounce:** hold "A" for 100 cycles; on release, glitch low for 2 cycles mid-DB_RELEASE, then clean release.
   - Exactly one `key_valid`, `key_code`=A.
   - Scan resumes only after 8 stable high cycles.
6. **Multi-key and reset:**
   - Rows 0 and 2 low together in col0 → `key_code`=1.
   - Assert `reset` at debounce count 5 of a new press → outputs return to reset values and no `key_valid` pulse occurs.
